// File: rtl/prefix_match_scheduler.sv
// Round-robin front end that time-shares one fast-prefix intersection engine across
// NUM_REQ lanes, tagging each streamed match and each job completion with the lane id.
module prefix_match_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int BITMASK_WIDTH = 128,
  parameter int WEIGHT_WIDTH  = 8,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int PW  = $clog2(BITMASK_WIDTH),
  localparam int CW  = PW + 1,
  localparam int DW  = BITMASK_WIDTH * WEIGHT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*BITMASK_WIDTH-1:0] req_bitmask_a,
  input  logic [NUM_REQ*BITMASK_WIDTH-1:0] req_bitmask_b,
  input  logic [NUM_REQ*DW-1:0]         req_fibre_b_data,
  output logic [BITMASK_WIDTH-1:0]      eng_and_result,
  output logic [BITMASK_WIDTH-1:0]      eng_bitmask_b,
  output logic [DW-1:0]                 eng_fibre_b_data,
  output logic                          eng_valid_match,
  input  logic                          eng_fast_valid,
  input  logic [PW-1:0]                 eng_matched_position,
  input  logic [PW-1:0]                 eng_fast_offset,
  input  logic [WEIGHT_WIDTH-1:0]       eng_matched_weight,
  input  logic                          eng_processing_done,
  output logic                          res_valid,
  output logic [IDW-1:0]                res_id,
  output logic [PW-1:0]                 res_position,
  output logic [PW-1:0]                 res_offset,
  output logic [WEIGHT_WIDTH-1:0]       res_weight,
  output logic                          done_valid,
  output logic [IDW-1:0]                done_id,
  output logic [CW-1:0]                 done_count,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]           rr_ptr_q;
  logic [IDW-1:0]           cur_id_q;
  logic [BITMASK_WIDTH-1:0] job_and_q;
  logic [BITMASK_WIDTH-1:0] job_b_q;
  logic [DW-1:0]            job_data_q;
  logic [CW-1:0]            match_cnt_q;

  logic                     res_valid_q;
  logic [IDW-1:0]           res_id_q;
  logic [PW-1:0]            res_position_q;
  logic [PW-1:0]            res_offset_q;
  logic [WEIGHT_WIDTH-1:0]  res_weight_q;
  logic                     done_valid_q;
  logic [IDW-1:0]           done_id_q;
  logic [CW-1:0]            done_count_q;

  logic                     grant_found;
  logic [IDW-1:0]           grant_id;
  logic                     grant_fire;
  logic [BITMASK_WIDTH-1:0] sel_a;
  logic [BITMASK_WIDTH-1:0] sel_b;
  logic [BITMASK_WIDTH-1:0] sel_and;
  logic [DW-1:0]            sel_data;

  // Lane index base+k folded back into 0..NUM_REQ-1 (works for non power-of-two counts).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    return IDW'(sum % NUM_REQ);
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel_a    = req_bitmask_a[k*BITMASK_WIDTH +: BITMASK_WIDTH];
        sel_b    = req_bitmask_b[k*BITMASK_WIDTH +: BITMASK_WIDTH];
        sel_data = req_fibre_b_data[k*DW +: DW];
      end
    end
  end

  assign sel_and = sel_a & sel_b;

  // No grant is handed out while reset is held, so req_ready stays low during reset.
  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (grant_found && !rst) begin
          grant_fire          = 1'b1;
          req_ready[grant_id] = 1'b1;
          state_d             = (|sel_and) ? ISSUE : FINISH;
        end
      end
      ISSUE:  state_d = WAIT;
      WAIT: begin
        if (eng_processing_done && !eng_fast_valid) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Job registers hold steady until the next grant; the engine reads them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      job_and_q   <= '0;
      job_b_q     <= '0;
      job_data_q  <= '0;
      match_cnt_q <= '0;
    end else begin
      if (grant_fire) begin
        rr_ptr_q    <= wrap_add(grant_id, 1);
        cur_id_q    <= grant_id;
        job_and_q   <= sel_and;
        job_b_q     <= sel_b;
        job_data_q  <= sel_data;
        match_cnt_q <= '0;
      end else if (state_q == ISSUE) begin
        match_cnt_q <= '0;
      end else if (state_q == WAIT && eng_fast_valid) begin
        match_cnt_q <= match_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q    <= 1'b0;
      res_id_q       <= '0;
      res_position_q <= '0;
      res_offset_q   <= '0;
      res_weight_q   <= '0;
    end else begin
      res_valid_q <= (state_q == WAIT) && eng_fast_valid;
      if (state_q == WAIT && eng_fast_valid) begin
        res_id_q       <= cur_id_q;
        res_position_q <= eng_matched_position;
        res_offset_q   <= eng_fast_offset;
        res_weight_q   <= eng_matched_weight;
      end
    end
  end

  // Completion is registered as FINISH is entered; an empty job reports zero matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_count_q <= '0;
    end else begin
      done_valid_q <= (state_d == FINISH);
      if (state_d == FINISH) begin
        done_id_q    <= grant_fire ? grant_id : cur_id_q;
        done_count_q <= grant_fire ? '0 : match_cnt_q;
      end
    end
  end

  assign eng_and_result   = job_and_q;
  assign eng_bitmask_b    = job_b_q;
  assign eng_fibre_b_data = job_data_q;
  assign eng_valid_match  = (state_q == ISSUE);
  assign busy             = (state_q != IDLE);

  assign res_valid    = res_valid_q;
  assign res_id       = res_id_q;
  assign res_position = res_position_q;
  assign res_offset   = res_offset_q;
  assign res_weight   = res_weight_q;
  assign done_valid   = done_valid_q;
  assign done_id      = done_id_q;
  assign done_count   = done_count_q;

endmodule

// File: tb/tb_prefix_match_scheduler.sv
// Bench for prefix_match_scheduler: behavioural engine plus a job-level scoreboard that
// predicts grants, tagged matches and completions from the lanes' own job contents.
module tb_prefix_match_scheduler;

  localparam int NR  = 4;
  localparam int BW  = 128;
  localparam int WW  = 8;
  localparam int IDW = 2;
  localparam int PW  = 7;
  localparam int CW  = 8;
  localparam int DW  = BW * WW;

  localparam int KIND_RAND  = 0;
  localparam int KIND_ONE   = 1;
  localparam int KIND_DENSE = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*BW-1:0]  req_bitmask_a;
  logic [NR*BW-1:0]  req_bitmask_b;
  logic [NR*DW-1:0]  req_fibre_b_data;
  logic [BW-1:0]     eng_and_result;
  logic [BW-1:0]     eng_bitmask_b;
  logic [DW-1:0]     eng_fibre_b_data;
  logic              eng_valid_match;
  logic              eng_fast_valid;
  logic [PW-1:0]     eng_matched_position;
  logic [PW-1:0]     eng_fast_offset;
  logic [WW-1:0]     eng_matched_weight;
  logic              eng_processing_done;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [PW-1:0]     res_position;
  logic [PW-1:0]     res_offset;
  logic [WW-1:0]     res_weight;
  logic              done_valid;
  logic [IDW-1:0]    done_id;
  logic [CW-1:0]     done_count;
  logic              busy;

  prefix_match_scheduler #(.NUM_REQ(NR), .BITMASK_WIDTH(BW), .WEIGHT_WIDTH(WW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bitmask_a(req_bitmask_a), .req_bitmask_b(req_bitmask_b),
    .req_fibre_b_data(req_fibre_b_data),
    .eng_and_result(eng_and_result), .eng_bitmask_b(eng_bitmask_b),
    .eng_fibre_b_data(eng_fibre_b_data), .eng_valid_match(eng_valid_match),
    .eng_fast_valid(eng_fast_valid), .eng_matched_position(eng_matched_position),
    .eng_fast_offset(eng_fast_offset), .eng_matched_weight(eng_matched_weight),
    .eng_processing_done(eng_processing_done),
    .res_valid(res_valid), .res_id(res_id), .res_position(res_position),
    .res_offset(res_offset), .res_weight(res_weight),
    .done_valid(done_valid), .done_id(done_id), .done_count(done_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] laneA [NR];
  logic [BW-1:0] laneB [NR];
  logic [DW-1:0] laneD [NR];
  int            jobsLeft [NR];
  int            laneKind [NR];
  logic [NR-1:0] acceptedMask = '0;

  int modelPtr = 0;
  int cycle = 0;
  int doneSeen = 0;
  int resSeen = 0;
  int expIssues = 0;
  int engIssues = 0;
  int lastDoneId = 0;
  int lastDoneCount = 0;
  int expPos[$], expOff[$], expW[$], expId[$];
  int expDoneId[$], expDoneCnt[$], expDoneCycle[$];
  int grantLog[$];
  int resPosLog[$], resOffLog[$], resWLog[$], resIdLog[$];
  int engPos[$], engOff[$], engW[$];

  int mg, mIdx, nMatch, mRank, mCyc, eRank;
  logic [NR-1:0] expOneHot;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offset of a match = how many fibre-B elements sit below that bit position.
  function automatic int rankBelow(input logic [BW-1:0] b, input int p);
    int r = 0;
    for (int q = 0; q < p; q++) if (b[q]) r++;
    return r;
  endfunction

  function automatic int weightAt(input logic [DW-1:0] d, input int slot);
    return int'(d[slot*WW +: WW]);
  endfunction

  function automatic logic [BW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic loadJob(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
    laneA[i] = a;
    laneB[i] = b;
    laneD[i] = d;
    req_bitmask_a[i*BW +: BW]  = a;
    req_bitmask_b[i*BW +: BW]  = b;
    req_fibre_b_data[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic genJob(input int i);
    logic [BW-1:0] a, b;
    logic [DW-1:0] d;
    int p;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    case (laneKind[i])
      KIND_ONE: begin
        p = $urandom_range(0, BW-1);
        a = '0;
        a[p] = 1'b1;
        b = rnd128();
        b[p] = 1'b1;
      end
      KIND_DENSE: begin
        a = BW'(16'hFFFF);
        b = BW'(16'hFFFF);
      end
      default: begin
        a = rnd128();
        b = rnd128();
        if ($urandom_range(0, 5) == 0) b = b & ~a;
      end
    endcase
    loadJob(i, a, b, d);
  endtask

  task automatic applyStimulus(input int i, input int kind, input int extraJobs);
    laneKind[i] = kind;
    jobsLeft[i] = extraJobs;
    genJob(i);
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (doneSeen < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("jobs_completed", doneSeen, target);
    #1;
  endtask

  // Lane queues: an accepted lane either presents its next job or drops valid.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acceptedMask[i]) begin
        acceptedMask[i] = 1'b0;
        if (jobsLeft[i] > 0) begin
          jobsLeft[i]--;
          genJob(i);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Behavioural engine: streams matches in ascending position with random stalls.
  always @(negedge clk) begin
    if (rst) begin
      engPos.delete(); engOff.delete(); engW.delete();
      eng_fast_valid = 1'b0;
      eng_processing_done = 1'b1;
    end else if (eng_valid_match) begin
      engIssues++;
      engPos.delete(); engOff.delete(); engW.delete();
      for (int p = 0; p < BW; p++) begin
        if (eng_and_result[p]) begin
          eRank = rankBelow(eng_bitmask_b, p);
          engPos.push_back(p);
          engOff.push_back(eRank);
          engW.push_back(weightAt(eng_fibre_b_data, eRank));
        end
      end
      eng_processing_done = 1'b0;
      eng_fast_valid = 1'b0;
    end else if (!eng_processing_done) begin
      if (engPos.size() == 0) begin
        eng_fast_valid = 1'b0;
        eng_processing_done = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        eng_fast_valid = 1'b0;
      end else begin
        eng_fast_valid = 1'b1;
        eng_matched_position = PW'(engPos.pop_front());
        eng_fast_offset = PW'(engOff.pop_front());
        eng_matched_weight = WW'(engW.pop_front());
      end
    end
  end

  // Scoreboard: predicts each grant and the full result stream of the granted job.
  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      if (req_ready != '0 || (!busy && req_valid != '0)) begin
        mg = -1;
        for (int k = 0; k < NR; k++) begin
          mIdx = (modelPtr + k) % NR;
          if (mg < 0 && req_valid[mIdx]) mg = mIdx;
        end
        expOneHot = '0;
        if (mg >= 0) expOneHot[mg] = 1'b1;
        checkOutput("grant", req_ready, expOneHot);
        checkOutput("busy_at_grant", busy, 1'b0);
        if (mg >= 0) begin
          grantLog.push_back(mg);
          modelPtr = (mg + 1) % NR;
          acceptedMask[mg] = 1'b1;
          nMatch = 0;
          for (int p = 0; p < BW; p++) begin
            if (laneA[mg][p] && laneB[mg][p]) begin
              mRank = rankBelow(laneB[mg], p);
              expPos.push_back(p);
              expOff.push_back(mRank);
              expW.push_back(weightAt(laneD[mg], mRank));
              expId.push_back(mg);
              nMatch++;
            end
          end
          expDoneId.push_back(mg);
          expDoneCnt.push_back(nMatch);
          expDoneCycle.push_back(nMatch == 0 ? cycle + 1 : -1);
          if (nMatch != 0) expIssues++;
        end
      end
      if (res_valid) begin
        resSeen++;
        resPosLog.push_back(int'(res_position));
        resOffLog.push_back(int'(res_offset));
        resWLog.push_back(int'(res_weight));
        resIdLog.push_back(int'(res_id));
        if (expPos.size() == 0) checkOutput("res_unexpected", res_valid, 1'b0);
        else begin
          checkOutput("res_id", res_id, expId.pop_front());
          checkOutput("res_position", res_position, expPos.pop_front());
          checkOutput("res_offset", res_offset, expOff.pop_front());
          checkOutput("res_weight", res_weight, expW.pop_front());
        end
      end
      if (done_valid) begin
        doneSeen++;
        lastDoneId = int'(done_id);
        lastDoneCount = int'(done_count);
        checkOutput("busy_at_done", busy, 1'b1);
        if (expDoneId.size() == 0) checkOutput("done_unexpected", done_valid, 1'b0);
        else begin
          checkOutput("done_id", done_id, expDoneId.pop_front());
          checkOutput("done_count", done_count, expDoneCnt.pop_front());
          checkOutput("done_after_last_res", expPos.size(), 0);
          mCyc = expDoneCycle.pop_front();
          if (mCyc >= 0) checkOutput("empty_done_latency", cycle, mCyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int target, base, gbase, issuesBefore, doneBefore, n;
    int rrOrder[5];
    logic [DW-1:0] d;
    rrOrder = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NR; i++) begin
      jobsLeft[i] = 0;
      laneKind[i] = KIND_RAND;
      laneA[i] = '0;
      laneB[i] = '0;
      laneD[i] = '0;
    end
    rst = 1'b1;
    req_bitmask_a = '0;
    req_bitmask_b = '0;
    req_fibre_b_data = '0;
    req_valid = 4'hF;
    eng_fast_valid = 1'b0;
    eng_processing_done = 1'b1;
    eng_matched_position = '0;
    eng_fast_offset = '0;
    eng_matched_weight = '0;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_done_valid", done_valid, 0);
    checkOutput("rst_eng_valid_match", eng_valid_match, 0);
    checkOutput("rst_done_count", done_count, 0);
    req_valid = '0;
    @(posedge clk);
    #2 rst = 1'b0;

    $display("[TB] single job on lane 0");
    d = '0;
    d[7:0] = 8'h11;
    d[15:8] = 8'h22;
    base = resSeen;
    target = doneSeen + 1;
    loadJob(0, BW'(8'h0F), BW'(8'h0A), d);
    waitDone(target, 100);
    checkOutput("t1_res_count", resSeen - base, 2);
    if (resSeen - base == 2) begin
      checkOutput("t1_pos0", resPosLog[base], 1);
      checkOutput("t1_off0", resOffLog[base], 0);
      checkOutput("t1_w0", resWLog[base], 8'h11);
      checkOutput("t1_pos1", resPosLog[base+1], 3);
      checkOutput("t1_off1", resOffLog[base+1], 1);
      checkOutput("t1_w1", resWLog[base+1], 8'h22);
      checkOutput("t1_id", resIdLog[base+1], 0);
    end
    checkOutput("t1_done_id", lastDoneId, 0);
    checkOutput("t1_done_count", lastDoneCount, 2);

    $display("[TB] empty intersection on lane 2");
    issuesBefore = engIssues;
    target = doneSeen + 1;
    loadJob(2, BW'(8'h0F), BW'(8'hF0), rnd128());
    waitDone(target, 50);
    checkOutput("t2_grant", grantLog[grantLog.size()-1], 2);
    checkOutput("t2_no_engine_start", engIssues, issuesBefore);
    checkOutput("t2_done_count", lastDoneCount, 0);
    checkOutput("t2_done_id", lastDoneId, 2);

    $display("[TB] wrap and skip from pointer 3");
    target = doneSeen + 1;
    applyStimulus(1, KIND_ONE, 0);
    waitDone(target, 100);
    checkOutput("t4_grant", grantLog[grantLog.size()-1], 1);
    gbase = grantLog.size();
    target = doneSeen + 3;
    for (int i = 1; i < NR; i++) applyStimulus(i, KIND_ONE, 0);
    waitDone(target, 300);
    checkOutput("t4_order0", grantLog[gbase], 2);
    checkOutput("t4_order1", grantLog[gbase+1], 3);
    checkOutput("t4_order2", grantLog[gbase+2], 1);
    target = doneSeen + 1;
    applyStimulus(3, KIND_ONE, 0);
    waitDone(target, 100);

    $display("[TB] round robin with all lanes pending");
    gbase = grantLog.size();
    target = doneSeen + 5;
    for (int i = 0; i < NR; i++) applyStimulus(i, KIND_ONE, (i == 0) ? 1 : 0);
    waitDone(target, 500);
    for (int k = 0; k < 5; k++) checkOutput("rr_order", grantLog[gbase+k], rrOrder[k]);
    checkOutput("rr_done_count", lastDoneCount, 1);

    $display("[TB] full mask");
    for (int k = 0; k < BW; k++) d[k*WW +: WW] = WW'(k);
    base = resSeen;
    target = doneSeen + 1;
    loadJob(0, '1, '1, d);
    waitDone(target, 400);
    checkOutput("full_res_count", resSeen - base, BW);
    checkOutput("full_last_offset", resOffLog[resOffLog.size()-1], BW-1);
    checkOutput("full_done_count", lastDoneCount, BW);

    $display("[TB] reset in the middle of a job");
    base = resSeen;
    applyStimulus(1, KIND_DENSE, 0);
    n = 0;
    while (resSeen < base + 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("mid_matches_seen", resSeen - base, 2);
    checkOutput("mid_busy_before", busy, 1);
    doneBefore = doneSeen;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_res_valid", res_valid, 0);
    checkOutput("arst_done_valid", done_valid, 0);
    checkOutput("arst_eng_valid_match", eng_valid_match, 0);
    checkOutput("arst_and_result", eng_and_result, 0);
    checkOutput("arst_fibre_data", |eng_fibre_b_data, 0);
    checkOutput("arst_res_position", res_position, 0);
    checkOutput("arst_done_count", done_count, 0);
    expPos.delete(); expOff.delete(); expW.delete(); expId.delete();
    expDoneId.delete(); expDoneCnt.delete(); expDoneCycle.delete();
    modelPtr = 0;
    acceptedMask = '0;
    req_valid = '0;
    for (int i = 0; i < NR; i++) jobsLeft[i] = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("arst_no_done", doneSeen, doneBefore);
    d = '0;
    d[7:0] = 8'h11;
    d[15:8] = 8'h22;
    target = doneSeen + 1;
    loadJob(2, BW'(8'h0F), BW'(8'h0A), d);
    waitDone(target, 100);
    checkOutput("post_rst_done_id", lastDoneId, 2);
    checkOutput("post_rst_done_count", lastDoneCount, 2);

    $display("[TB] randomized jobs on all lanes");
    target = doneSeen + 12;
    for (int i = 0; i < NR; i++) applyStimulus(i, KIND_RAND, 2);
    waitDone(target, 12 * 300);

    repeat (3) @(posedge clk);
    checkOutput("engine_starts", engIssues, expIssues);
    checkOutput("pending_matches", expPos.size(), 0);
    checkOutput("pending_done", expDoneId.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefix_match_scheduler.md
Name: prefix_match_scheduler

Overview:
- Round-robin scheduler that shares one fast-prefix intersection engine among NUM_REQ requesters (PE lanes).
- Accepts a fibre-pair job (bitmask A, bitmask B, packed fibre-B weights) from the winning requester and computes and_result = A & B.
- Sequences the engine through its valid_match / processing_done handshake, tags each streamed match with the requester id, and reports a per-job completion with the match count.
- Sits between the lane job queues and the engine.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥2.
- BITMASK_WIDTH, 128, fibre bitmask width.
- WEIGHT_WIDTH, 8, weight width.
- Derived: IDW = $clog2(NUM_REQ), PW = $clog2(BITMASK_WIDTH), CW = PW+1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester job pending.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
- req_bitmask_a  in  NUM_REQ*BITMASK_WIDTH  packed; slice i belongs to requester i.
- req_bitmask_b  in  NUM_REQ*BITMASK_WIDTH  packed.
- req_fibre_b_data  in  NUM_REQ*BITMASK_WIDTH*WEIGHT_WIDTH  packed.
- eng_and_result  out  BITMASK_WIDTH  to engine.
- eng_bitmask_b  out  BITMASK_WIDTH  to engine.
- eng_fibre_b_data  out  BITMASK_WIDTH*WEIGHT_WIDTH  to engine.
- eng_valid_match  out  1  one-cycle job start to engine.
- eng_fast_valid  in  1  from engine.
- eng_matched_position  in  PW  from engine.
- eng_fast_offset  in  PW  from engine.
- eng_matched_weight  in  WEIGHT_WIDTH  from engine.
- eng_processing_done  in  1  from engine; high when the engine is idle.
- res_valid  out  1  tagged match strobe.
- res_id  out  IDW  requester id for the match.
- res_position  out  PW  matched position.
- res_offset  out  PW  matched offset.
- res_weight  out  WEIGHT_WIDTH  matched weight.
- done_valid  out  1  one-cycle job-complete strobe.
- done_id  out  IDW  requester id of the completed job.
- done_count  out  CW  number of matches in the job.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async): every output and internal register goes to 0, state = IDLE, RR pointer = 0.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward (with wrap) from the RR pointer.
  - Pulse req_ready[g] for that cycle.
  - Latch the requester's A&B, B and data into job registers; latch cur_id = g.
  - Set RR pointer = (g+1) mod NUM_REQ.
  - If A&B == 0, go to FINISH with count 0; the engine is not started. Otherwise go to ISSUE.
- ISSUE: drive eng_valid_match = 1 for exactly this cycle, clear match_cnt, go to WAIT.
- WAIT:
  - The engine's processing_done is low from the first WAIT cycle.
  - On each eng_fast_valid, increment match_cnt and register the match onto res_* with res_valid = 1 on the next cycle. Latency is 1 cycle; res_id = cur_id.
  - When eng_processing_done == 1 and eng_fast_valid == 0, go to FINISH.
- FINISH: done_valid = 1, done_id = cur_id, done_count = match_cnt (registered); then go to IDLE.
- eng_and_result, eng_bitmask_b and eng_fibre_b_data come from the job registers. They stay stable from ISSUE until the following grant, because the engine reads the data combinationally while it runs.
- Results have no backpressure: res_valid and done_valid are single-cycle strobes and consumers must always accept them.
- res_valid for the last match of a job always precedes or coincides with that job's done_valid; it is never later.
- match_cnt is CW bits wide and cannot overflow (at most BITMASK_WIDTH matches per job).
- req_valid deasserting while not granted has no effect. Requests arriving outside IDLE wait for IDLE.
- Minimum throughput: one grant per IDLE visit; an empty-intersection job takes 2 cycles, IDLE→FINISH→IDLE.
- rst asserted mid-job returns to IDLE immediately. No done_valid is emitted for the aborted job, and the engine is assumed reset by the same rst.

Test Plan:
1. Single job: req 0, A=0x...0F, B=0x...0A (bits 1 and 3), weights w0=0x11, w1=0x22. Required: res_valid twice, (pos 1, off 0, w 0x11) then (pos 3, off 1, w 0x22), res_id=0; then done_valid with done_id=0, done_count=2.
2. Empty intersection: A & B = 0 on req 2. Required: req_ready[2] pulse, eng_valid_match never asserted, done_valid 1 cycle later with count 0.
3. Round-robin: all 4 requesters valid continuously, each with 1 match. Required: grant order 0,1,2,3,0; each done_count=1; no requester granted twice before all others have been granted.
4. Wrap and skip: pointer=3, only req 1 valid. Required: req 1 granted and pointer becomes 2.
5. Full mask: A = B = all-ones. Required: 128 res_valid strobes with offsets 0..127 in order, then done_count=128 (CW=8 bits).
6. Reset mid-WAIT after 2 matches. Required: all outputs 0 asynchronously, no done_valid, and a new job after reset completes normally.
